// File: rtl/sobel_pkg.sv
// Shared types for the sobel frame controller: one-hot state encoding,
// the pixel type and the counter-width helper.
package sobel_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ARM   = 5'b00010,
        ST_FEED  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } state_e;

    typedef logic [7:0] pixel_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sobel_frame_counter.sv
// Up-counter with synchronous clear and enable. o_tc is high while the
// count equals TERM.
module sobel_frame_counter
    import sobel_pkg::*;
#(
    parameter int TERM = 12,
    parameter int W    = cnt_width(TERM)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count enabled events; clear has priority over enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == W'(TERM));

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer in front of one sobel_channel_filter. Admits exactly
// WIDTH_P*HEIGHT_P pixels per frame, resets the filter at frame start,
// waits for the filter to drain and tags its output with sof/eof.
// Optional watchdog: define SOBEL_FRAME_CTRL_TIMEOUT_EN.
//
// Source handshake: a pixel transfers on a clock edge where src_valid_i
// and src_ready_o are both high; src_valid_i may not depend on src_ready_o.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P  = 10,
    parameter int HEIGHT_P = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        src_valid_i,
    input  logic [7:0]  src_pixel_i,
    output logic        src_ready_o,
    output logic        flt_reset_o,
    output logic        flt_valid_o,
    output logic [7:0]  flt_pixel_o,
    input  logic        flt_valid_i,
    input  logic [7:0]  flt_pixel_i,
    output logic        out_valid_o,
    output logic [7:0]  out_pixel_o,
    output logic        out_sof_o,
    output logic        out_eof_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] frame_cnt_o
);

    localparam int PIX_N = WIDTH_P * HEIGHT_P;
    localparam int CNT_W = cnt_width(PIX_N);

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
    localparam int FEED_TMO  = 4096;
    localparam int DRAIN_TMO = WIDTH_P + 8;
    localparam int WDOG_MAX  = (DRAIN_TMO > FEED_TMO) ? DRAIN_TMO : FEED_TMO;
    localparam int WDOG_W    = cnt_width(WDOG_MAX);
    logic [WDOG_W-1:0] r_wdog;
`endif

    state_e           r_state;
    logic             r_flt_reset;
    logic             r_src_ready;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_frame_cnt;
    logic             r_out_valid;
    logic             r_out_sof;
    logic             r_out_eof;
    pixel_t           r_out_pixel;
    pixel_t           r_flt_pix_hold;

    logic             w_hs;
    logic             w_in_last;
    logic [CNT_W-1:0] w_in_cnt;
    logic [CNT_W-1:0] w_out_cnt;
    logic             w_out_tc;
    logic             w_out_win;
    logic             w_out_acc;
    logic             w_err_set;
    logic             w_arm;
    logic             w_unused;

    assign w_hs      = src_valid_i & r_src_ready;
    assign w_arm     = (r_state == ST_ARM);
    assign w_out_win = (r_state == ST_FEED) | (r_state == ST_DRAIN);
    // A filter output is kept only inside the frame window and only until
    // PIX_N outputs have been taken; anything else is a protocol error.
    assign w_out_acc = flt_valid_i & w_out_win & ~w_out_tc;
    assign w_err_set = flt_valid_i & ~w_out_acc;

    // The input count is only consumed through its last-pixel flag.
    assign w_unused  = &{1'b0, w_in_cnt};

    sobel_frame_counter #(.TERM(PIX_N - 1), .W(CNT_W)) u_in_cnt (
        .i_clk (clk_i),
        .i_rst (reset_i),
        .i_clr (w_arm),
        .i_en  (w_hs),
        .o_cnt (w_in_cnt),
        .o_tc  (w_in_last)
    );

    sobel_frame_counter #(.TERM(PIX_N), .W(CNT_W)) u_out_cnt (
        .i_clk (clk_i),
        .i_rst (reset_i),
        .i_clr (w_arm),
        .i_en  (w_out_acc),
        .o_cnt (w_out_cnt),
        .o_tc  (w_out_tc)
    );

    // Frame sequencing with registered control outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_flt_reset <= 1'b1;
            r_src_ready <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
            r_wdog      <= '0;
`endif
        end else begin
            r_flt_reset <= 1'b0;
            r_done      <= 1'b0;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (r_state == ST_ARM) begin
                r_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state     <= ST_ARM;
                        r_flt_reset <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_state     <= ST_FEED;
                    r_src_ready <= 1'b1;
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
                    r_wdog      <= '0;
`endif
                end
                ST_FEED: begin
                    if (w_hs && w_in_last) begin
                        r_state     <= ST_DRAIN;
                        r_src_ready <= 1'b0;
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
                        r_wdog      <= '0;
`endif
                    end
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
                    else if (w_hs) begin
                        r_wdog <= '0;
                    end else if (r_wdog == WDOG_W'(FEED_TMO - 1)) begin
                        r_state     <= ST_DONE;
                        r_src_ready <= 1'b0;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (w_out_tc) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
                    else if (r_wdog == WDOG_W'(DRAIN_TMO - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_src_ready <= 1'b0;
                end
            endcase
        end
    end

    // Remember the last accepted pixel so the filter input is stable when idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_flt_pix_hold <= '0;
        end else if (w_hs) begin
            r_flt_pix_hold <= src_pixel_i;
        end
    end

    // Register filter output and tag the first and last pixel of the frame.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_pixel <= '0;
        end else begin
            r_out_valid <= w_out_acc;
            r_out_sof   <= w_out_acc && (w_out_cnt == '0);
            r_out_eof   <= w_out_acc && (w_out_cnt == CNT_W'(PIX_N - 1));
            if (w_out_acc) begin
                r_out_pixel <= flt_pixel_i;
            end
        end
    end

    assign src_ready_o = r_src_ready;
    assign flt_reset_o = r_flt_reset;
    assign flt_valid_o = w_hs;
    assign flt_pixel_o = w_hs ? src_pixel_i : r_flt_pix_hold;
    assign out_valid_o = r_out_valid;
    assign out_pixel_o = r_out_pixel;
    assign out_sof_o   = r_out_sof;
    assign out_eof_o   = r_out_eof;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with W=4, H=3 and a behavioural
// filter stand-in: it emits nothing for the first W+1 inputs, then one
// output per input, then its last W+1 outputs back-to-back with no input.
// Output k equals input k XOR 8'h5A.
module tb_sobel_frame_ctrl;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int PIX_N = W * H;
  localparam int BUDGET = 300;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        src_valid_i;
  logic [7:0]  src_pixel_i;
  logic        src_ready_o;
  logic        flt_reset_o;
  logic        flt_valid_o;
  logic [7:0]  flt_pixel_o;
  logic        flt_valid_i;
  logic [7:0]  flt_pixel_i;
  logic        out_valid_o;
  logic [7:0]  out_pixel_o;
  logic        out_sof_o;
  logic        out_eof_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] frame_cnt_o;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  sobel_frame_ctrl #(.WIDTH_P(W), .HEIGHT_P(H)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .src_valid_i (src_valid_i),
    .src_pixel_i (src_pixel_i),
    .src_ready_o (src_ready_o),
    .flt_reset_o (flt_reset_o),
    .flt_valid_o (flt_valid_o),
    .flt_pixel_o (flt_pixel_o),
    .flt_valid_i (flt_valid_i),
    .flt_pixel_i (flt_pixel_i),
    .out_valid_o (out_valid_o),
    .out_pixel_o (out_pixel_o),
    .out_sof_o   (out_sof_o),
    .out_eof_o   (out_eof_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .frame_cnt_o (frame_cnt_o)
  );

  // filter stand-in
  logic [7:0] mdl_mem [0:PIX_N-1];
  int         mdl_in;
  int         mdl_out;
  logic       mdl_valid;
  logic [7:0] mdl_pix;
  logic       stub_en;
  logic       stub_valid;

  always @(posedge clk_i) begin
    if (flt_reset_o) begin
      mdl_in    <= 0;
      mdl_out   <= 0;
      mdl_valid <= 1'b0;
      mdl_pix   <= 8'h00;
    end else begin
      mdl_valid <= 1'b0;
      if (flt_valid_o && mdl_in < PIX_N) begin
        mdl_mem[mdl_in] <= flt_pixel_o;
        mdl_in <= mdl_in + 1;
        if (mdl_in >= W + 1) begin
          mdl_valid <= 1'b1;
          mdl_pix   <= mdl_mem[mdl_out] ^ 8'h5A;
          mdl_out   <= mdl_out + 1;
        end
      end else if (mdl_in == PIX_N && mdl_out < PIX_N) begin
        mdl_valid <= 1'b1;
        mdl_pix   <= mdl_mem[mdl_out] ^ 8'h5A;
        mdl_out   <= mdl_out + 1;
      end
    end
  end

  assign flt_valid_i = stub_en ? stub_valid : mdl_valid;
  assign flt_pixel_i = stub_en ? 8'hEE : mdl_pix;

  // scoreboard and per-frame statistics
  logic [7:0]  exp_q[$];
  logic [15:0] exp_frames;
  int n_out, n_sof, n_eof, sof_bad, eof_bad, pix_bad;
  int n_done, n_err, n_flt_rst, n_ready_late, n_busy_post;
  bit timed_out;

  function automatic logic [7:0] pix_of(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // driver: one full frame, start pulse to a few cycles after done_o
  task automatic run_frame(input bit toggle, input bit restart_on_done);
    int sent;
    int cyc;
    int post;
    logic [7:0] e;
    exp_q.delete();
    for (int i = 0; i < PIX_N; i++) exp_q.push_back(pix_of(i) ^ 8'h5A);
    n_out = 0; n_sof = 0; n_eof = 0; sof_bad = 0; eof_bad = 0; pix_bad = 0;
    n_done = 0; n_err = 0; n_flt_rst = 0; n_ready_late = 0; n_busy_post = 0;
    timed_out = 1'b0;
    sent = 0; cyc = 0; post = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    while (cyc < BUDGET && post < 4) begin
      @(negedge clk_i);
      if (flt_reset_o) n_flt_rst++;
      if (src_ready_o && sent == PIX_N) n_ready_late++;
      if (out_valid_o) begin
        if (out_sof_o) begin
          n_sof++;
          if (n_out != 0) sof_bad++;
        end
        if (out_eof_o) begin
          n_eof++;
          if (n_out != PIX_N - 1) eof_bad++;
        end
        if (exp_q.size() == 0) pix_bad++;
        else begin
          e = exp_q.pop_front();
          if (out_pixel_o !== e) pix_bad++;
        end
        n_out++;
      end
      if (err_o) n_err++;
      if (n_done > 0 && !done_o && busy_o) n_busy_post++;
      if (done_o) n_done++;
      if (n_done > 0) post++;
      start_i = done_o && restart_on_done;
      if (sent < PIX_N && (!toggle || cyc % 2 == 0)) begin
        src_valid_i = 1'b1;
        src_pixel_i = pix_of(sent);
      end else begin
        src_valid_i = 1'b0;
      end
      if (src_valid_i && src_ready_o) sent++;
      cyc++;
    end
    src_valid_i = 1'b0;
    start_i = 1'b0;
    if (cyc >= BUDGET) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; src_valid_i = 1'b0; src_pixel_i = 8'h00;
    stub_en = 1'b0; stub_valid = 1'b0;
    exp_frames = 16'd0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (flt_reset_o !== 1'b1) begin errors++; $display("FAIL reset_flt_reset got=%b exp=1", flt_reset_o); end
    checks++;
    if ({src_ready_o, flt_valid_o, out_valid_o, out_sof_o, out_eof_o, busy_o, done_o, err_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {src_ready_o, flt_valid_o, out_valid_o, out_sof_o, out_eof_o, busy_o, done_o, err_o});
    end
    checks++;
    if (frame_cnt_o !== 16'd0 || out_pixel_o !== 8'h00) begin
      errors++; $display("FAIL reset_counts frame_cnt=%0d pixel=%0h exp=0/0", frame_cnt_o, out_pixel_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (flt_reset_o !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", flt_reset_o); end
    @(negedge clk_i);
    checks++;
    if (flt_reset_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle flt_reset=%b busy=%b exp=0/0", flt_reset_o, busy_o);
    end
  endtask

  task automatic test_single_frame();
    run_frame(1'b0, 1'b0);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (timed_out) begin errors++; $display("FAIL single_timeout frame did not complete in %0d cycles", BUDGET); end
    checks++;
    if (n_flt_rst !== 1) begin errors++; $display("FAIL single_flt_reset_cycles got=%0d exp=1", n_flt_rst); end
    checks++;
    if (n_ready_late !== 0) begin errors++; $display("FAIL single_ready_drop late_cycles=%0d exp=0", n_ready_late); end
    checks++;
    if (n_out !== PIX_N) begin errors++; $display("FAIL single_out_count got=%0d exp=%0d", n_out, PIX_N); end
    checks++;
    if (n_sof !== 1 || sof_bad !== 0) begin errors++; $display("FAIL single_sof count=%0d misplaced=%0d exp=1/0", n_sof, sof_bad); end
    checks++;
    if (n_eof !== 1 || eof_bad !== 0) begin errors++; $display("FAIL single_eof count=%0d misplaced=%0d exp=1/0", n_eof, eof_bad); end
    checks++;
    if (pix_bad !== 0) begin errors++; $display("FAIL single_pixels wrong=%0d exp=0", pix_bad); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL single_done pulses=%0d exp=1", n_done); end
    checks++;
    if (frame_cnt_o !== exp_frames) begin errors++; $display("FAIL single_frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_frames); end
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL single_err cycles=%0d exp=0", n_err); end
    checks++;
    if (flt_pixel_o !== pix_of(PIX_N - 1)) begin
      errors++; $display("FAIL single_flt_pixel_hold got=%0h exp=%0h", flt_pixel_o, pix_of(PIX_N - 1));
    end
  endtask

  task automatic test_stalled_source();
    run_frame(1'b1, 1'b0);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (timed_out || n_out !== PIX_N) begin errors++; $display("FAIL stall_out_count got=%0d exp=%0d", n_out, PIX_N); end
    checks++;
    if (pix_bad !== 0 || sof_bad !== 0 || eof_bad !== 0) begin
      errors++; $display("FAIL stall_sequence wrong=%0d sof_bad=%0d eof_bad=%0d exp=0/0/0", pix_bad, sof_bad, eof_bad);
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL stall_done pulses=%0d exp=1", n_done); end
    checks++;
    if (frame_cnt_o !== exp_frames) begin errors++; $display("FAIL stall_frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_frames); end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b1);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (n_busy_post !== 0) begin errors++; $display("FAIL b2b_start_in_done busy_cycles=%0d exp=0", n_busy_post); end
    // source offers data while idle: nothing reaches the filter
    @(negedge clk_i);
    src_valid_i = 1'b1;
    src_pixel_i = 8'hC3;
    #1;
    checks++;
    if (flt_valid_o !== 1'b0 || src_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_block flt_valid=%b src_ready=%b exp=0/0", flt_valid_o, src_ready_o);
    end
    checks++;
    if (flt_pixel_o !== pix_of(PIX_N - 1)) begin
      errors++; $display("FAIL b2b_idle_pixel_hold got=%0h exp=%0h", flt_pixel_o, pix_of(PIX_N - 1));
    end
    src_valid_i = 1'b0;
    run_frame(1'b0, 1'b0);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (n_out !== PIX_N || n_done !== 1) begin
      errors++; $display("FAIL b2b_second_frame outs=%0d done=%0d exp=%0d/1", n_out, n_done, PIX_N);
    end
    checks++;
    if (frame_cnt_o !== exp_frames) begin errors++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_frames); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b exp=0", err_o); end
  endtask

  task automatic test_idle_error();
    int outs;
    outs = 0;
    @(negedge clk_i);
    stub_en = 1'b1;
    stub_valid = 1'b1;
    @(negedge clk_i);
    if (out_valid_o) outs++;
    stub_valid = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL idle_err_set got=%b exp=1", err_o); end
    @(negedge clk_i);
    if (out_valid_o) outs++;
    stub_en = 1'b0;
    checks++;
    if (outs !== 0) begin errors++; $display("FAIL idle_err_output out_valid_cycles=%0d exp=0", outs); end
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL idle_err_sticky got=%b exp=1", err_o); end
    run_frame(1'b0, 1'b0);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL idle_err_clear got=%b exp=0", err_o); end
    checks++;
    if (n_out !== PIX_N || frame_cnt_o !== exp_frames) begin
      errors++; $display("FAIL idle_err_frame outs=%0d frame_cnt=%0d exp=%0d/%0d", n_out, frame_cnt_o, PIX_N, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (sent < 5 && cyc < 50) begin
      @(negedge clk_i);
      src_valid_i = 1'b1;
      src_pixel_i = pix_of(sent);
      if (src_ready_o) sent++;
      cyc++;
    end
    @(negedge clk_i);
    src_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || src_ready_o !== 1'b1) begin
      errors++; $display("FAIL midrst_in_feed busy=%b src_ready=%b exp=1/1", busy_o, src_ready_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || src_ready_o !== 1'b0 || flt_reset_o !== 1'b1) begin
      errors++; $display("FAIL midrst_async busy=%b src_ready=%b flt_reset=%b exp=0/0/1", busy_o, src_ready_o, flt_reset_o);
    end
    exp_frames = 16'd0;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    run_frame(1'b0, 1'b0);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (timed_out || n_out !== PIX_N || pix_bad !== 0 || n_done !== 1) begin
      errors++; $display("FAIL midrst_recover outs=%0d wrong=%0d done=%0d exp=%0d/0/1", n_out, pix_bad, n_done, PIX_N);
    end
    checks++;
    if (frame_cnt_o !== exp_frames) begin errors++; $display("FAIL midrst_frame_cnt got=%0d exp=%0d", frame_cnt_o, exp_frames); end
  endtask

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int sent;
    int k;
    int done_at;
    int cyc;
    sent = 0; k = -1; done_at = -1; cyc = 0;
    stub_en = 1'b1;
    stub_valid = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    while (done_at < 0 && cyc < BUDGET) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (sent == PIX_N) k++;
      if (done_o) done_at = k;
      src_valid_i = (sent < PIX_N);
      src_pixel_i = pix_of(sent);
      if (src_valid_i && src_ready_o) sent++;
      cyc++;
    end
    src_valid_i = 1'b0;
    checks++;
    if (done_at !== W + 8) begin errors++; $display("FAIL timeout_done_cycle got=%0d exp=%0d", done_at, W + 8); end
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", err_o); end
    @(negedge clk_i);
    checks++;
    if (frame_cnt_o !== exp_frames || busy_o !== 1'b0) begin
      errors++; $display("FAIL timeout_frame_cnt got=%0d busy=%b exp=%0d/0", frame_cnt_o, busy_o, exp_frames);
    end
    stub_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_stalled_source();
    test_back_to_back();
    test_idle_error();
    test_reset_mid_frame();
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
